// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU constants and the issue-stage state type.
package alu_pkg;
    localparam int ALU_WIDTH = 4;
    typedef enum logic [1:0] {IDLE, EVAL, DONE} mod_state_t;
endpackage

// File: rtl/mod_issue_stage_if.sv
// mod_issue_stage_if: operand/result valid-ready handshakes plus the op counter.
//   master: drives in_valid/in_a/in_b/out_ready; slave: drives in_ready/out_valid/out_r/out_err/op_count.
interface mod_issue_stage_if import alu_pkg::*; #(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int COUNT_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_r;
    logic               out_err;
    logic [COUNT_W-1:0] op_count;
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_r, out_err, op_count
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_r, out_err, op_count
    );
endinterface

// File: rtl/modulus4.sv
// modulus4: combinational remainder r = a mod b (r = 0 when b = 0).
//   a, b: operands; r: remainder.
module modulus4 import alu_pkg::*; (
    input  logic [ALU_WIDTH-1:0] a,
    input  logic [ALU_WIDTH-1:0] b,
    output logic [ALU_WIDTH-1:0] r
);
    assign r = (b == '0) ? '0 : a % b;
endmodule

// File: rtl/mod_issue_stage.sv
// mod_issue_stage: registered issue/capture stage around modulus4.
//   clk, rst: clock and sync active-high reset; bus: slave side of the operand/result handshakes.
module mod_issue_stage import alu_pkg::*; #(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int COUNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    mod_issue_stage_if.slave bus
);
    mod_state_t         state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, r_q, m_r;
    logic               err_q, in_ready, out_valid, in_fire, out_fire;
    logic [COUNT_W-1:0] cnt_q;

    modulus4 u_mod (.a(a_q), .b(b_q), .r(m_r));

    // in_ready in DONE is a pass-through of out_ready so a new pair can issue on the retiring edge.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                state_d  = (bus.in_valid && !rst) ? EVAL : IDLE;
            end
            EVAL: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready && !rst;
                state_d   = !bus.out_ready ? DONE : (bus.in_valid ? EVAL : IDLE);
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (in_fire) begin
                a_q <= bus.in_a;
                b_q <= bus.in_b;
            end
            if (state_q == EVAL) begin
                r_q   <= (b_q == '0) ? '0 : m_r;
                err_q <= (b_q == '0);
            end
            if (out_fire) cnt_q <= cnt_q + COUNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_r     = r_q;
    assign bus.out_err   = err_q;
    assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_mod_issue_stage.sv
// tb_mod_issue_stage: directed + random checks of mod_issue_stage against a remainder/counter model.
module tb_mod_issue_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cnt = 0;

    mod_issue_stage_if #(.WIDTH(4), .COUNT_W(8)) bus ();
    mod_issue_stage #(.WIDTH(4), .COUNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic int ref_r(int a, int b);
        return (b == 0) ? 0 : a % b;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts just after a negedge in IDLE, ends just after the retiring negedge back in IDLE.
    task automatic op(int a, int b, int stall, bit poke);
        int er = ref_r(a, b);
        int ee = (b == 0) ? 1 : 0;
        bus.in_a = 4'(a); bus.in_b = 4'(b); bus.in_valid = 1'b1; bus.out_ready = (stall == 0);
        #1 chk("accept_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 chk("eval_valid", int'(bus.out_valid), 0);
        chk("eval_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        for (int s = 0; s < stall; s++) begin
            bus.in_valid = poke;
            bus.in_a = 4'(a + 5); bus.in_b = 4'(b + 1);
            #1 chk("stall_valid", int'(bus.out_valid), 1);
            chk("stall_r", int'(bus.out_r), er);
            chk("stall_err", int'(bus.out_err), ee);
            chk("stall_in_ready", int'(bus.in_ready), 0);
            chk("stall_count", int'(bus.op_count), cnt);
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1 chk("done_valid", int'(bus.out_valid), 1);
        chk("done_r", int'(bus.out_r), er);
        chk("done_err", int'(bus.out_err), ee);
        chk("done_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        cnt = (cnt + 1) % 256;
        #1 chk("op_count", int'(bus.op_count), cnt);
        chk("idle_valid", int'(bus.out_valid), 0);
    endtask

    initial begin
        int sa[4] = '{9, 9, 15, 8};
        int sb[4] = '{2, 3, 7, 5};
        rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_a = '0; bus.in_b = '0;
        repeat (2) @(negedge clk);
        #1 chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_r", int'(bus.out_r), 0);
        chk("rst_err", int'(bus.out_err), 0);
        chk("rst_count", int'(bus.op_count), 0);
        rst = 1'b0;
        #1 chk("post_rst_ready", int'(bus.in_ready), 1);

        op(9, 4, 0, 0);

        // Back-to-back stream: each retiring edge also accepts the next pair.
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_a = 4'(sa[0]); bus.in_b = 4'(sb[0]);
        #1 chk("stream_accept", int'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 chk("stream_eval_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        for (int k = 1; k < 4; k++) begin
            bus.in_valid = 1'b1; bus.in_a = 4'(sa[k]); bus.in_b = 4'(sb[k]);
            #1 chk("stream_valid", int'(bus.out_valid), 1);
            chk("stream_r", int'(bus.out_r), ref_r(sa[k-1], sb[k-1]));
            chk("stream_in_ready", int'(bus.in_ready), 1);
            @(negedge clk);
            cnt++;
            bus.in_valid = 1'b0;
            #1 chk("stream_count", int'(bus.op_count), cnt);
            chk("stream_gap_valid", int'(bus.out_valid), 0);
            @(negedge clk);
        end
        #1 chk("stream_last_r", int'(bus.out_r), ref_r(sa[3], sb[3]));
        @(negedge clk);
        cnt++;
        #1 chk("stream_final_count", int'(bus.op_count), cnt);
        chk("stream_idle", int'(bus.out_valid), 0);

        op(7, 0, 0, 0);
        op(8, 5, 0, 0);
        op(9, 3, 5, 1);

        for (int i = 0; i < 30; i++)
            op(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(3)), 1'($urandom_range(1)));

        // Reset lands on the EVAL edge of 15/7: nothing is emitted and the counter clears.
        bus.in_a = 4'd15; bus.in_b = 4'd7; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        cnt = 0;
        #1 chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_r", int'(bus.out_r), 0);
        chk("mid_rst_err", int'(bus.out_err), 0);
        chk("mid_rst_count", int'(bus.op_count), 0);
        chk("mid_rst_in_ready", int'(bus.in_ready), 0);
        rst = 1'b0;
        #1 chk("mid_rst_release_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        #1 chk("mid_rst_no_result", int'(bus.out_valid), 0);

        for (int i = 0; i < 256; i++) op(i % 16, 3, 0, 0);
        chk("wrap_count", int'(bus.op_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
